// File: rtl/io_input_cond.sv
// Button/switch conditioning for the MMIO input ports: synchroniser, per-button debounce,
// sticky W1C press flags and a combinational-read register file. Optional macro: BTN_IRQ_EN.
module io_input_cond #(
    parameter int NUM_BTN         = 4,
    parameter int NUM_SW          = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    input  logic [NUM_SW-1:0]  i_sw_raw,
    output logic [NUM_BTN-1:0] o_btn_lvl,
    output logic [NUM_SW-1:0]  o_sw_lvl,
    input  logic               i_we,
    input  logic [3:0]         i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_BTN-1:0] BTN_IDLE =
        (BTN_ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

    localparam logic [1:0] A_SW   = 2'd0;
    localparam logic [1:0] A_BTN  = 2'd1;
    localparam logic [1:0] A_FLAG = 2'd2;
    localparam logic [1:0] A_MASK = 2'd3;

    logic [NUM_BTN-1:0] r_btn_sync [SYNC_STAGES];
    logic [NUM_SW-1:0]  r_sw_sync  [SYNC_STAGES];
    logic [CW-1:0]      r_cnt      [NUM_BTN];
    logic [CW-1:0]      w_cnt_next [NUM_BTN];
    logic [NUM_BTN-1:0] r_btn_lvl;
    logic [NUM_BTN-1:0] r_flag;
    logic [NUM_BTN-1:0] w_btn_synced;
    logic [NUM_BTN-1:0] w_lvl_next;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_flag_clr;
    logic [31:0]        w_rdata;
    logic               w_unused;

    // Sync flops reset to the released pad level so no phantom press follows reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_btn_sync[s] <= BTN_IDLE;
                r_sw_sync[s]  <= '0;
            end
        end else begin
            r_btn_sync[0] <= i_btn_raw;
            r_sw_sync[0]  <= i_sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_btn_sync[s] <= r_btn_sync[s-1];
                r_sw_sync[s]  <= r_sw_sync[s-1];
            end
        end
    end

    assign w_btn_synced = (BTN_ACTIVE_LOW != 0) ? ~r_btn_sync[SYNC_STAGES-1]
                                                : r_btn_sync[SYNC_STAGES-1];
    assign o_sw_lvl     = r_sw_sync[SYNC_STAGES-1];

    // Any cycle of agreement zeroes the counter; the level flips on the count that hits max.
    always_comb begin
        w_lvl_next = r_btn_lvl;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_cnt_next[i] = '0;
            if (w_btn_synced[i] != r_btn_lvl[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_lvl_next[i] = w_btn_synced[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press    = w_lvl_next & ~r_btn_lvl;
    assign w_flag_clr = (i_we && i_addr[3:2] == A_FLAG) ? i_wdata[NUM_BTN-1:0] : '0;

    // A press edge on the same edge as its W1C clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= '0;
            end
            r_btn_lvl <= '0;
            r_flag    <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_btn_lvl <= w_lvl_next;
            r_flag    <= (r_flag & ~w_flag_clr) | w_press;
        end
    end

    assign o_btn_lvl = r_btn_lvl;

`ifdef BTN_IRQ_EN
    logic [NUM_BTN-1:0] r_mask;
    logic               r_irq;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (i_we && i_addr[3:2] == A_MASK) begin
                r_mask <= i_wdata[NUM_BTN-1:0];
            end
            r_irq <= |(r_flag & r_mask);
        end
    end

    assign o_irq = r_irq;
`else
    assign o_irq = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (i_addr[3:2])
            A_SW:   w_rdata[NUM_SW-1:0]  = r_sw_sync[SYNC_STAGES-1];
            A_BTN:  w_rdata[NUM_BTN-1:0] = r_btn_lvl;
            A_FLAG: w_rdata[NUM_BTN-1:0] = r_flag;
`ifdef BTN_IRQ_EN
            A_MASK: w_rdata[NUM_BTN-1:0] = r_mask;
`endif
            default: w_rdata = '0;
        endcase
    end

    assign o_rdata  = w_rdata;
    assign w_unused = &{1'b0, i_addr[1:0], i_wdata};

endmodule
